// File: rtl/uart_print_arbiter_if.sv
// Bundle between the debug requesters / UART byte transmitter and the print arbiter.
// Bytes move on any rising edge with O_tx_valid && I_tx_ready; O_tx_data holds otherwise; requesters hold I_req_valid/data until their O_req_ready pulse.
interface uart_print_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        I_req_valid;
  logic [NUM_REQ*DATA_W-1:0] I_req_data;
  logic [NUM_REQ-1:0]        O_req_ready;
  logic [7:0]                O_tx_data;
  logic                      O_tx_valid;
  logic                      I_tx_ready;
  logic                      O_busy;
  logic [ID_W-1:0]           O_grant_id;
  logic                      O_dbg_state;

  modport slave (
    input  I_req_valid, I_req_data, I_tx_ready,
    output O_req_ready, O_tx_data, O_tx_valid, O_busy, O_grant_id, O_dbg_state
  );

  modport master (
    output I_req_valid, I_req_data, I_tx_ready,
    input  O_req_ready, O_tx_data, O_tx_valid, O_busy, O_grant_id, O_dbg_state
  );
endinterface

// File: rtl/uart_print_arbiter.sv
// Round-robin share of one UART byte channel; each granted value is printed
// as "<tag>:<uppercase hex>\r\n", MSB nibble first.
module uart_print_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter int          DATA_W   = 32,
  parameter logic [7:0]  TAG_BASE = 8'h41
) (
  input  logic               I_clk,
  input  logic               I_rst,
  uart_print_arbiter_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NIBS  = DATA_W / 4;
  localparam int LEN   = NIBS + 4;
  localparam int IDX_W = $clog2(LEN);

  localparam logic [IDX_W-1:0] IDX_COLON = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_DIG0  = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_CR    = IDX_W'(LEN - 2);
  localparam logic [IDX_W-1:0] IDX_LF    = IDX_W'(LEN - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    gnt_q, gnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] rdy_q, rdy_d;

  logic               found;
  logic [ID_W-1:0]    pick;
  logic [NUM_REQ-1:0] rot;
  int                 cand;
  logic [3:0]         nib;
  logic [7:0]         hex_byte;
  logic [7:0]         tx_byte;

  // First valid requester after the pointer, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    rot   = '0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      rot = bus.I_req_valid >> cand;
      if (!found && rot[0]) begin
        found = 1'b1;
        pick  = ID_W'(cand);
      end
    end
  end

  // The captured payload shifts left per accepted digit, so the top nibble is always next.
  assign nib      = data_q[DATA_W-1 -: 4];
  assign hex_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});

  always_comb begin
    tx_byte = hex_byte;
    if (idx_q == '0)             tx_byte = TAG_BASE + 8'(gnt_q);
    else if (idx_q == IDX_COLON) tx_byte = 8'h3A;
    else if (idx_q == IDX_CR)    tx_byte = 8'h0D;
    else if (idx_q == IDX_LF)    tx_byte = 8'h0A;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      gnt_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      rdy_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    rdy_d   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SEND;
          ptr_d   = pick;
          gnt_d   = pick;
          data_d  = DATA_W'(bus.I_req_data >> (int'(pick) * DATA_W));
          idx_d   = '0;
          rdy_d   = NUM_REQ'(1) << pick;
        end
      end
      SEND: begin
        if (bus.I_tx_ready) begin
          if (idx_q == IDX_LF) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
          if (idx_q >= IDX_DIG0 && idx_q < IDX_CR) data_d = data_q << 4;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.O_tx_valid  = (state_q == SEND);
  assign bus.O_busy      = (state_q == SEND);
  assign bus.O_tx_data   = (state_q == SEND) ? tx_byte : 8'h00;
  assign bus.O_req_ready = rdy_q;
  assign bus.O_grant_id  = gnt_q;
  assign bus.O_dbg_state = state_q;
endmodule

// File: tb/tb_uart_print_arbiter.sv
// Bench for uart_print_arbiter: requester model feeds directed payloads, a negedge
// monitor pops expected bytes/grants from queues and compares.
module tb_uart_print_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;

  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  uart_print_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();
  uart_print_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TAG_BASE(8'h41)) dut (
    .I_clk(clk), .I_rst(rst), .bus(bus)
  );

  uart_print_arbiter_if #(.NUM_REQ(2), .DATA_W(8)) vbus ();
  uart_print_arbiter #(.NUM_REQ(2), .DATA_W(8), .TAG_BASE(8'h41)) dut_v (
    .I_clk(clk), .I_rst(rst), .bus(vbus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int         exp_gnt_q[$];

  logic [DW-1:0] rq_data[NR][16];
  int            rq_head[NR];
  int            rq_tail[NR];
  logic [NR-1:0] seen_rdy;

  logic bp_mode;
  logic stall_force;
  logic chk_gap;
  int   acc_cnt;
  int   gnt_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic queue_req(input int id, input logic [DW-1:0] d);
    rq_data[id][rq_tail[id]] = d;
    rq_tail[id]++;
  endtask

  task automatic expect_msg(input int id, input logic [DW-1:0] d);
    exp_gnt_q.push_back(id);
    exp_q.push_back(8'h41 + 8'(id));
    exp_q.push_back(8'h3A);
    for (int k = DW/4 - 1; k >= 0; k--) exp_q.push_back(hex_ch(d[k*4 +: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic expect_line(input int id, input logic [95:0] b);
    exp_gnt_q.push_back(id);
    for (int k = 0; k < 12; k++) exp_q.push_back(b[95 - 8*k -: 8]);
  endtask

  task automatic wait_drain(input int budget);
    bool_loop: begin
      for (int c = 0; c < budget; c++) begin
        @(negedge clk);
        #2;
        if (exp_q.size() == 0 && exp_gnt_q.size() == 0 && !bus.O_busy &&
            rq_head[0] == rq_tail[0] && rq_head[1] == rq_tail[1] &&
            rq_head[2] == rq_tail[2] && rq_head[3] == rq_tail[3]) disable bool_loop;
      end
      fail_msg("drain_timeout");
    end
    repeat (3) @(negedge clk);
  endtask

  // Requester model: hold valid/data until the pulse has been seen, then move on.
  initial begin
    bus.I_req_valid = '0;
    bus.I_req_data  = '0;
    seen_rdy        = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (seen_rdy[i]) rq_head[i]++;
        seen_rdy[i] = bus.O_req_ready[i];
        if (rq_head[i] < rq_tail[i]) begin
          bus.I_req_valid[i]          = 1'b1;
          bus.I_req_data[i*DW +: DW]  = rq_data[i][rq_head[i]];
        end else begin
          bus.I_req_valid[i]          = 1'b0;
          bus.I_req_data[i*DW +: DW]  = 32'h5A5A_5A5A;
        end
      end
    end
  end

  initial begin
    bus.I_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_force)  bus.I_tx_ready = 1'b0;
      else if (bp_mode) bus.I_tx_ready = ($urandom_range(0, 9) < 3);
      else              bus.I_tx_ready = 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic       prev_stall, prev_rst, prev_valid, end_pending, gap_armed;
    logic [7:0] prev_data;
    logic [NR-1:0] prev_rdy;
    int         idle_run, e;
    prev_stall = 0; prev_rst = 1; prev_valid = 0; end_pending = 0; gap_armed = 0;
    prev_data = '0; prev_rdy = '0; idle_run = 0;
    acc_cnt = 0; gnt_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall && !prev_rst) begin
          check("stall_valid", bus.O_tx_valid, 1);
          check("stall_data", bus.O_tx_data, prev_data);
        end
        if (end_pending) check("busy_fall", {bus.O_busy, bus.O_tx_valid}, 0);
        if (bus.O_req_ready != '0) begin
          gnt_cnt++;
          check("ready_width", prev_rdy, 0);
          if (exp_gnt_q.size() == 0) fail_msg("unexpected_grant");
          else begin
            e = exp_gnt_q.pop_front();
            check("ready_pulse", bus.O_req_ready, NR'(1) << e);
            check("grant_id", bus.O_grant_id, e);
            check("ready_first_send", {bus.O_busy, bus.O_tx_valid}, 2'b11);
          end
        end
        if (bus.O_tx_valid && !prev_valid) begin
          if (gap_armed) check("idle_gap", idle_run, 1);
          gap_armed = 0;
        end
        if (!bus.O_tx_valid) idle_run++;
        else idle_run = 0;
        end_pending = 0;
        if (bus.O_tx_valid && bus.I_tx_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) fail_msg("unexpected_byte");
          else begin
            check("tx_byte", bus.O_tx_data, exp_q.pop_front());
            if (bus.O_tx_data == 8'h0A) begin
              end_pending = 1;
              gap_armed   = chk_gap && (exp_q.size() > 0);
            end
          end
        end
      end
      prev_stall = bus.O_tx_valid && !bus.I_tx_ready;
      prev_data  = bus.O_tx_data;
      prev_rst   = rst;
      prev_rdy   = bus.O_req_ready;
      prev_valid = bus.O_tx_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] vexp;
    int          got, base;
    rst = 1'b1;
    bp_mode = 1'b0; stall_force = 1'b0; chk_gap = 1'b0;
    vbus.I_req_valid = '0;
    vbus.I_req_data  = '0;
    vbus.I_tx_ready  = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", bus.O_tx_valid, 0);
    check("rst_ready", bus.O_req_ready, 0);
    check("rst_data", bus.O_tx_data, 0);
    check("rst_busy", bus.O_busy, 0);
    check("rst_grant", bus.O_grant_id, 0);
    check("rst_state", bus.O_dbg_state, 0);

    // Arbitration: 0 and 2 together, then everyone.
    chk_gap = 1'b1;
    expect_msg(0, 32'h0123_4567);
    expect_msg(2, 32'h89AB_CDEF);
    expect_msg(3, 32'h00C0_FFEE);
    expect_msg(0, 32'hA5A5_0F0F);
    expect_msg(1, 32'h1357_9BDF);
    expect_msg(2, 32'h2468_ACE0);
    #2;
    queue_req(0, 32'h0123_4567);
    queue_req(2, 32'h89AB_CDEF);
    queue_req(2, 32'h2468_ACE0);
    begin : wait_g2
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        #2;
        if (gnt_cnt >= 2) disable wait_g2;
      end
      fail_msg("arb_grant2_timeout");
    end
    queue_req(0, 32'hA5A5_0F0F);
    queue_req(1, 32'h1357_9BDF);
    queue_req(3, 32'h00C0_FFEE);
    wait_drain(200);
    chk_gap = 1'b0;

    // Single request, literal byte stream.
    expect_line(0, 96'h41_3A_31_32_33_34_41_42_43_44_0D_0A);
    #2 queue_req(0, 32'h1234_ABCD);
    wait_drain(60);

    // Backpressure at roughly 30% ready.
    bp_mode = 1'b1;
    expect_line(0, 96'h41_3A_46_46_46_46_30_30_30_30_0D_0A);
    #2 queue_req(0, 32'hFFFF_0000);
    wait_drain(400);
    bp_mode = 1'b0;

    // Payload change after capture: requester switches to a garbage value.
    expect_msg(1, 32'hDEAD_BEEF);
    #2 queue_req(1, 32'hDEAD_BEEF);
    wait_drain(60);

    // Reset mid-message after byte 5 is accepted.
    exp_gnt_q.push_back(1);
    exp_q.push_back(8'h42); exp_q.push_back(8'h3A); exp_q.push_back(8'h30);
    exp_q.push_back(8'h42); exp_q.push_back(8'h41); exp_q.push_back(8'h44);
    base = acc_cnt;
    #2 queue_req(1, 32'h0BAD_F00D);
    begin : wait_b5
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        #2;
        if (acc_cnt >= base + 6) disable wait_b5;
      end
      fail_msg("byte5_timeout");
    end
    stall_force = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", bus.O_tx_valid, 0);
    check("mid_rst_busy", bus.O_busy, 0);
    check("mid_rst_ready", bus.O_req_ready, 0);
    check("mid_rst_grant", bus.O_grant_id, 0);
    check("mid_rst_data", bus.O_tx_data, 0);
    stall_force = 1'b0;
    expect_msg(0, 32'h7777_0001);
    expect_msg(3, 32'h3333_000F);
    #2;
    queue_req(3, 32'h3333_000F);
    queue_req(0, 32'h7777_0001);
    wait_drain(100);

    // Narrow variant: 2 requesters, 8-bit payload.
    vexp = 48'h42_3A_46_30_0D_0A;
    vbus.I_req_data  = {8'hF0, 8'h00};
    vbus.I_req_valid = 2'b10;
    begin : wait_v
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (vbus.O_req_ready != '0) disable wait_v;
      end
      fail_msg("v_grant_timeout");
    end
    check("v_ready", vbus.O_req_ready, 2'b10);
    check("v_grant", vbus.O_grant_id, 1);
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin
        vbus.I_req_valid = 2'b00;
        vbus.I_req_data  = {8'h11, 8'h00};
      end
      if (vbus.O_tx_valid) begin
        check("v_byte", vbus.O_tx_data, vexp[47 - 8*got -: 8]);
        got++;
      end
    end
    if (got < 6) fail_msg("v_bytes_timeout");
    @(negedge clk);
    check("v_busy_fall", {vbus.O_busy, vbus.O_tx_valid}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_print_arbiter.md
Name: uart_print_arbiter

Overview:
- Shares the board's single UART TX byte channel between NUM_REQ debug requesters, such as camera status, frame counters and HDMI timing monitors. This block implements the "Print Control" function.
- Each request carries one DATA_W-bit value. The block grants requests round-robin and formats the granted value as an ASCII line: tag, colon, uppercase hex digits, CR, LF.
- Bytes go to the downstream UART byte transmitter over a valid/ready handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, payload width. Must be a multiple of 4, range 4..64.
- TAG_BASE, 8'h41, ASCII tag for requester 0. Requester i uses TAG_BASE+i ('A','B',...).

Ports:
- I_clk  in  1  block clock. All logic is on its rising edge.
- I_rst  in  1  synchronous reset, active-high.
- I_req_valid  in  NUM_REQ  per-requester print request.
- I_req_data  in  NUM_REQ*DATA_W  payloads. Requester i occupies bits [i*DATA_W +: DATA_W].
- O_req_ready  out  NUM_REQ  one-cycle accept pulse per requester.
- O_tx_data  out  8  ASCII byte to the UART transmitter.
- O_tx_valid  out  1  O_tx_data is valid.
- I_tx_ready  in  1  UART transmitter accepts the byte this cycle.
- O_busy  out  1  a message is in progress.
- O_grant_id  out  max(1,clog2(NUM_REQ))  id of the current or last granted requester.

Behaviour:
- Reset values (I_rst high at an edge): state=IDLE, O_req_ready=0, O_tx_valid=0, O_tx_data=0, O_busy=0, O_grant_id=0. Round-robin pointer=NUM_REQ-1, so requester 0 wins first. Reset mid-message truncates the message and drops O_tx_valid the next cycle. No resume, no flush.
- Message length LEN = DATA_W/4 + 4 bytes, in this order:
  - TAG_BASE+id
  - 8'h3A (':')
  - DATA_W/4 hex digits, MSB nibble first. Nibble n maps to 8'h30+n for n<10, else 8'h37+n (uppercase A–F).
  - 8'h0D
  - 8'h0A
- FSM IDLE:
  - If any I_req_valid is high at edge N, grant the first valid id searching pointer+1, pointer+2, ... with wrap at NUM_REQ.
  - Capture that requester's data into an internal register. Set pointer=O_grant_id=grant.
  - Move to SEND.
  - At cycle N+1: O_req_ready[grant]=1 for exactly one cycle, O_busy=1, O_tx_valid=1 with byte 0.
- Requester contract:
  - Hold valid and data stable until O_req_ready is seen.
  - Deassert valid (or present a new value) from the cycle after the pulse.
  - Payload changes after capture do not affect the message in flight.
- FSM SEND:
  - Byte index 0..LEN-1. On O_tx_valid && I_tx_ready the index advances and the next byte is presented the following cycle.
  - While O_tx_valid && !I_tx_ready, O_tx_data and the index hold; no byte is dropped or duplicated.
  - O_tx_valid stays high through the whole message, with no gaps when I_tx_ready is continuously high.
  - On acceptance of byte LEN-1: return to IDLE, with O_tx_valid=0 and O_busy=0 the next cycle.
- Minimum spacing between messages: one IDLE cycle. At full throughput a message occupies LEN+1 cycles from request sample to the next sample.
- Valid requests are never lost; they wait.
- Fairness: after a grant, a continuously asserted requester waits at most NUM_REQ-1 messages.
- O_grant_id holds its value in IDLE.
- Only one bit of O_req_ready is high at a time, and only in the first SEND cycle.

Test Plan:
- Single request, default params, I_tx_ready=1: req0 with data 32'h1234ABCD.
  -> O_req_ready[0] is a one-cycle pulse.
  -> 12 consecutive bytes: 41 3A 31 32 33 34 41 42 43 44 0D 0A.
  -> O_busy falls the cycle after 0A.
- Arbitration order: req0 and req2 raised simultaneously, then all four held continuously.
  -> Order: 0, 2, 3, 0, 1, 2.
  -> Tags 41, 43, 44, 41, 42, 43.
  -> Exactly one IDLE cycle between messages.
- Backpressure: I_tx_ready pseudo-random at 30% duty, data 32'hFFFF0000.
  -> Byte stream is exactly 41 3A 46 46 46 46 30 30 30 30 0D 0A.
  -> O_tx_data is stable whenever valid && !ready.
- Reset mid-message: I_rst pulsed after byte 5 is accepted, then req3 and req0 both valid.
  -> O_tx_valid=0 the cycle after reset.
  -> req0 is granted first (tag 41), then req3 (tag 44).
- Payload change after capture: req1 data changes right after O_req_ready.
  -> Transmitted digits reflect the captured value only.
- Parameter variant: NUM_REQ=2, DATA_W=8, req1 data 8'hF0.
  -> 6 bytes: 42 3A 46 30 0D 0A.
